// File: rtl/score_event_arbiter.sv
// -----------------------------------------------------------------------------
// score_event_arbiter
//
// Takes one-shot scoring hits from N_TARGETS hit detectors and puts them on a
// single valid/ready event port, using round-robin arbitration. The port feeds
// the HUD, sound and hex display. The block also owns the round score and the
// win indication that the game FSM reads.
//
// Each target is armed at the start of a round. A hit on an armed target,
// seen while round_active is high, latches that target's point value and
// disarms the target. The target then stays pending until the arbiter moves
// it into the output register. The pending flag is registered: a capture at
// one edge can be arbitrated at the next edge at the earliest. This gives a
// minimum hit-to-event latency of two cycles.
//
// Ports
//   Clk          in   clock
//   Reset        in   async reset, active-high
//   round_start  in   1-cycle pulse: re-arm targets, clear score/queue/output
//   round_active in   level: hits are captured only while high
//   hit_req      in   [N_TARGETS]          per-target hit level
//   hit_points   in   [N_TARGETS*POINTS_W] points of target i at [i*POINTS_W +: POINTS_W]
//   evt_valid    out  output register holds a scored hit
//   evt_ready    in   consumer accepts the event
//   evt_id       out  [ID_W]      index of the scored target
//   evt_points   out  [POINTS_W]  points carried by the event
//   grant        out  [N_TARGETS] one-hot pulse in the cycle an event is loaded
//   score        out  [SCORE_W]   saturating sum of accepted event points
//   round_won    out  score >= WIN_SCORE
//   won_pulse    out  high for one cycle when round_won rises
// -----------------------------------------------------------------------------
module score_event_arbiter #(
  parameter int N_TARGETS = 3,
  parameter int POINTS_W  = 4,
  parameter int SCORE_W   = 11,
  parameter int WIN_SCORE = 3,
  localparam int ID_W     = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          round_start,
  input  logic                          round_active,
  input  logic [N_TARGETS-1:0]          hit_req,
  input  logic [N_TARGETS*POINTS_W-1:0] hit_points,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [ID_W-1:0]               evt_id,
  output logic [POINTS_W-1:0]           evt_points,
  output logic [N_TARGETS-1:0]          grant,
  output logic [SCORE_W-1:0]            score,
  output logic                          round_won,
  output logic                          won_pulse
);

  logic [N_TARGETS-1:0] armed_q,   armed_d;
  logic [N_TARGETS-1:0] pending_q, pending_d;
  logic [POINTS_W-1:0]  pts_q [N_TARGETS];
  logic [POINTS_W-1:0]  pts_d [N_TARGETS];
  logic [ID_W-1:0]      rr_ptr_q,     rr_ptr_d;
  logic                 evt_valid_q,  evt_valid_d;
  logic [ID_W-1:0]      evt_id_q,     evt_id_d;
  logic [POINTS_W-1:0]  evt_points_q, evt_points_d;
  logic [N_TARGETS-1:0] grant_q,      grant_d;
  logic [SCORE_W-1:0]   score_q,      score_d;
  logic                 won_pulse_q,  won_pulse_d;

  logic                 accept;
  logic                 load_slot;
  logic                 found;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W:0]        cand;
  logic [SCORE_W:0]     sum_full;
  logic [SCORE_W-1:0]   sum_sat;

  assign accept    = evt_valid_q & evt_ready;
  // The output slot can take a new event when it is empty or is being drained.
  assign load_slot = ~evt_valid_q | evt_ready;

  // The sum is one bit wider than score, so the carry-out shows an overflow
  // and the result saturates at all ones.
  assign sum_full = {1'b0, score_q} + (SCORE_W+1)'(evt_points_q);
  assign sum_sat  = sum_full[SCORE_W] ? '1 : sum_full[SCORE_W-1:0];

  // Round-robin search. The scan starts at rr_ptr_q and wraps modulo
  // N_TARGETS. cand has one extra bit so rr_ptr_q + k cannot overflow before
  // the wrap.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_TARGETS; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_TARGETS)) cand = cand - (ID_W+1)'(N_TARGETS);
      if (!found && pending_q[cand[ID_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    armed_d      = armed_q;
    pending_d    = pending_q;
    pts_d        = pts_q;
    rr_ptr_d     = rr_ptr_q;
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    evt_points_d = evt_points_q;
    grant_d      = '0;
    score_d      = score_q;

    if (round_start) begin
      // A new round overrides everything. An event accepted in this same
      // cycle is dropped and not scored, and hits in this cycle are ignored.
      armed_d      = '1;
      pending_d    = '0;
      rr_ptr_d     = '0;
      evt_valid_d  = 1'b0;
      evt_id_d     = '0;
      evt_points_d = '0;
      score_d      = '0;
    end else begin
      if (accept) score_d = sum_sat;

      if (load_slot) begin
        if (found) begin
          evt_valid_d        = 1'b1;
          evt_id_d           = win_idx;
          evt_points_d       = pts_q[win_idx];
          pending_d[win_idx] = 1'b0;
          grant_d[win_idx]   = 1'b1;
          rr_ptr_d           = (32'(win_idx) == N_TARGETS - 1) ? '0 : win_idx + 1'b1;
        end else begin
          evt_valid_d = 1'b0;
        end
      end

      // Capture runs after arbitration. The arbiter above reads only
      // pending_q, so a hit captured at this edge cannot be granted until
      // the next edge. A disarmed target cannot be captured again, so this
      // never clashes with the pending bit that was cleared above.
      for (int i = 0; i < N_TARGETS; i++) begin
        if (round_active && armed_q[i] && hit_req[i]) begin
          pending_d[i] = 1'b1;
          armed_d[i]   = 1'b0;
          pts_d[i]     = hit_points[i*POINTS_W +: POINTS_W];
        end
      end
    end

    // The pulse is registered and lines up with the first cycle of round_won.
    won_pulse_d = (score_d >= SCORE_W'(WIN_SCORE)) & ~round_won;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      armed_q      <= '1;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_points_q <= '0;
      grant_q      <= '0;
      score_q      <= '0;
      won_pulse_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      armed_q      <= armed_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_points_q <= evt_points_d;
      grant_q      <= grant_d;
      score_q      <= score_d;
      won_pulse_q  <= won_pulse_d;
    end
  end

  // NOTE: pts_q is read only while the matching pending bit is set, so this data array is left without a reset.
  always_ff @(posedge Clk) begin
    pts_q <= pts_d;
  end

  assign evt_valid  = evt_valid_q;
  assign evt_id     = evt_id_q;
  assign evt_points = evt_points_q;
  assign grant      = grant_q;
  assign score      = score_q;
  assign round_won  = score_q >= SCORE_W'(WIN_SCORE);
  assign won_pulse  = won_pulse_q;

endmodule
